// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle fetch/decode/sequencing controller owning PC and
//               IR, driving all datapath controls and resolving branches.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int          PC_W    = 10,
  parameter logic [3:0]  ALU_ADD = 4'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic [31:0]     rs_data,
  output logic [3:0]      rs_addr,
  output logic [3:0]      rt_addr,
  output logic [3:0]      rd_addr,
  output logic            reg_dst,
  output logic            wr_reg,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic            immSel,
  output logic [31:0]     imm_signed,
  output logic [31:0]     jmp_signed,
  output logic            rdMem,
  output logic            wrMem,
  output logic            mToReg,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h01;
  localparam logic [5:0] c_OP_LD    = 6'h02;
  localparam logic [5:0] c_OP_ST    = 6'h03;
  localparam logic [5:0] c_OP_BZ    = 6'h04;
  localparam logic [5:0] c_OP_BMI   = 6'h05;
  localparam logic [5:0] c_OP_BR    = 6'h06;
  localparam logic [5:0] c_OP_HALT  = 6'h3F;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [31:0]     r_ir;
  logic [5:0]      w_op;
  logic            w_ctl_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (r_state == S_DECODE) begin
        r_ir <= imem_data;
      end
    end
  end

  assign w_op       = r_ir[31:26];
  assign rs_addr    = r_ir[25:22];
  assign rt_addr    = r_ir[21:18];
  assign rd_addr    = r_ir[17:14];
  assign imm_signed = {{16{r_ir[15]}}, r_ir[15:0]};
  assign jmp_signed = {{10{r_ir[21]}}, r_ir[21:0]};
  assign imem_addr  = r_pc;
  assign pc         = r_pc;

  // Datapath controls are a pure decode of IR, held for the whole EXEC..WB span
  assign w_ctl_active = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    alu_control = 4'h0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    immSel      = 1'b0;
    if (w_ctl_active) begin
      case (w_op)
        c_OP_RTYPE: begin
          alu_control = r_ir[3:0];
          alu_src     = 1'b1;
          reg_dst     = 1'b1;
        end
        c_OP_ADDI, c_OP_LD, c_OP_ST: begin
          alu_control = ALU_ADD;
        end
        c_OP_BR: begin
          immSel = 1'b1;
        end
        default: begin
          alu_control = 4'h0;
        end
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    wr_reg       = 1'b0;
    rdMem        = 1'b0;
    wrMem        = 1'b0;
    mToReg       = 1'b0;
    illegal_op   = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_next_pc    = r_pc + PC_W'(1);
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        // pc already points past this instruction, so offsets are from addr+1
        case (w_op)
          c_OP_RTYPE, c_OP_ADDI: w_next_state = S_WB;
          c_OP_LD, c_OP_ST:      w_next_state = S_MEM;
          c_OP_BZ: begin
            if (rs_data == 32'h0) w_next_pc = r_pc + imm_signed[PC_W-1:0];
            w_next_state = S_FETCH;
          end
          c_OP_BMI: begin
            if (rs_data[31]) w_next_pc = r_pc + imm_signed[PC_W-1:0];
            w_next_state = S_FETCH;
          end
          c_OP_BR: begin
            w_next_pc    = r_pc + jmp_signed[PC_W-1:0];
            w_next_state = S_FETCH;
          end
          c_OP_HALT: w_next_state = S_HALTED;
          default: begin
            illegal_op   = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (w_op == c_OP_LD) begin
          rdMem        = 1'b1;
          mToReg       = 1'b1;
          w_next_state = S_WB;
        end else begin
          wrMem        = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_WB: begin
        wr_reg = 1'b1;
        if (w_op == c_OP_LD) begin
          rdMem  = 1'b1;
          mToReg = 1'b1;
        end
        w_next_state = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed table-driven bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  localparam int PC_W = 10;
  localparam logic [31:0] c_NOP = 32'h1800_0000; // BR +0

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_q;
  logic [31:0]     rs_data;
  logic [3:0]      rs_addr, rt_addr, rd_addr;
  logic            reg_dst, wr_reg, alu_src, immSel;
  logic [3:0]      alu_control;
  logic [31:0]     imm_signed, jmp_signed;
  logic            rdMem, wrMem, mToReg;
  logic [PC_W-1:0] pc;
  logic            halted, illegal_op;

  logic [31:0] imem [0:(1<<PC_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_q <= imem[imem_addr];

  multicycle_control #(.PC_W(PC_W), .ALU_ADD(4'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_q), .rs_data(rs_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .reg_dst(reg_dst), .wr_reg(wr_reg), .alu_control(alu_control),
    .alu_src(alu_src), .immSel(immSel), .imm_signed(imm_signed),
    .jmp_signed(jmp_signed), .rdMem(rdMem), .wrMem(wrMem), .mToReg(mToReg),
    .pc(pc), .halted(halted), .illegal_op(illegal_op)
  );

  typedef struct {
    int          at;
    logic [31:0] instr;
    logic [31:0] rs;
    int          lat;
    int          nxt;
    int          wr_cnt;
    int          wr_cyc;
    int          rd_cnt;
    int          mtr_cnt;
    int          wm_cnt;
    int          ill_cnt;
    logic [6:0]  ctl;   // {alu_control, alu_src, reg_dst, immSel}
    logic [31:0] imm;
    logic [31:0] jmp;
    logic [11:0] regs;  // {rs, rt, rd}
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] ins_i(input logic [5:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [15:0] imm);
    return {op, rs, rt, 2'b00, imm};
  endfunction

  function automatic logic [31:0] ins_r(input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [3:0] rd, input logic [3:0] fn);
    return {6'h00, rs, rt, rd, 10'h000, fn};
  endfunction

  function automatic logic [31:0] ins_j(input logic [5:0] op, input logic [3:0] rs,
                                        input logic [21:0] off);
    return {op, rs, off};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic any_strobe();
    return wr_reg | rdMem | wrMem | mToReg | illegal_op;
  endfunction

  task automatic reset_fill();
    reset   = 1'b0;
    start   = 1'b0;
    rs_data = 32'h0;
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = c_NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leaves the bench at the sample point of cycle 1 (FETCH) of the word at pc 0
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int first_wr, n_wr, n_rd, n_mtr, n_wm, n_ill, bad;

    vecs[0]  = '{0,    ins_i(6'h01, 4'h0, 4'h2, 16'hFFFB), 32'h0,        4, 1,  1, 4, 0, 0, 0, 0,
                 7'b0000_000, 32'hFFFF_FFFB, 32'h0008_FFFB, 12'h023};
    vecs[1]  = '{3,    ins_r(4'h1, 4'h2, 4'h3, 4'h5),     32'h0,        4, 4,  1, 4, 0, 0, 0, 0,
                 7'b0101_110, 32'hFFFF_C005, 32'h0008_C005, 12'h123};
    vecs[2]  = '{1,    ins_i(6'h02, 4'h3, 4'h4, 16'h0010), 32'h0,        5, 2,  1, 5, 2, 2, 0, 0,
                 7'b0000_000, 32'h0000_0010, 32'h0010_0010, 12'h340};
    vecs[3]  = '{2,    ins_i(6'h03, 4'h3, 4'h4, 16'h8000), 32'h0,        4, 3,  0, 0, 0, 0, 1, 0,
                 7'b0000_000, 32'hFFFF_8000, 32'h0010_8000, 12'h342};
    vecs[4]  = '{5,    ins_i(6'h04, 4'h1, 4'h0, 16'hFFFC), 32'h0,        3, 2,  0, 0, 0, 0, 0, 0,
                 7'b0000_000, 32'hFFFF_FFFC, 32'h0000_FFFC, 12'h103};
    vecs[5]  = '{5,    ins_i(6'h04, 4'h1, 4'h0, 16'hFFFC), 32'h7,        3, 6,  0, 0, 0, 0, 0, 0,
                 7'b0000_000, 32'hFFFF_FFFC, 32'h0000_FFFC, 12'h103};
    vecs[6]  = '{4,    ins_i(6'h05, 4'h1, 4'h0, 16'h0005), 32'h8000_0000, 3, 10, 0, 0, 0, 0, 0, 0,
                 7'b0000_000, 32'h0000_0005, 32'h0000_0005, 12'h100};
    vecs[7]  = '{4,    ins_i(6'h05, 4'h1, 4'h0, 16'h0005), 32'h7FFF_FFFF, 3, 5,  0, 0, 0, 0, 0, 0,
                 7'b0000_000, 32'h0000_0005, 32'h0000_0005, 12'h100};
    vecs[8]  = '{1023, ins_j(6'h06, 4'h0, 22'h000003),    32'h0,        3, 3,  0, 0, 0, 0, 0, 0,
                 7'b0000_001, 32'h0000_0003, 32'h0000_0003, 12'h000};
    vecs[9]  = '{8,    ins_j(6'h06, 4'h0, 22'h3FFFFE),    32'h0,        3, 7,  0, 0, 0, 0, 0, 0,
                 7'b0000_001, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 12'h0FF};
    vecs[10] = '{6,    ins_j(6'h2A, 4'h0, 22'h000000),    32'h0,        3, 7,  0, 0, 0, 0, 0, 1,
                 7'b0000_000, 32'h0000_0000, 32'h0000_0000, 12'h000};

    // Reset state, sampled while reset is asserted and just after release
    reset = 1'b0; start = 1'b0; rs_data = 32'h0;
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = c_NOP;
    #1;
    chk("rst_strobes", 64'(any_strobe()), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_ctl", 64'({alu_control, alu_src, reg_dst, immSel}), 64'h0);

    foreach (vecs[v]) begin
      reset_fill();
      imem[vecs[v].at] = vecs[v].instr;
      rs_data = vecs[v].rs;
      launch();
      repeat (3 * vecs[v].at) @(negedge clk);
      first_wr = 0; n_wr = 0; n_rd = 0; n_mtr = 0; n_wm = 0; n_ill = 0;
      for (int c = 1; c <= vecs[v].lat; c++) begin
        if (wr_reg && first_wr == 0) first_wr = c;
        n_wr += int'(wr_reg); n_rd += int'(rdMem); n_mtr += int'(mToReg);
        n_wm += int'(wrMem);  n_ill += int'(illegal_op);
        if (c < 3)
          chk($sformatf("v%0d_ctl_c%0d", v, c),
              64'({alu_control, alu_src, reg_dst, immSel}), 64'h0);
        else
          chk($sformatf("v%0d_ctl_c%0d", v, c),
              64'({alu_control, alu_src, reg_dst, immSel}), 64'(vecs[v].ctl));
        if (c == 3) begin
          chk($sformatf("v%0d_imm", v), 64'(imm_signed), 64'(vecs[v].imm));
          chk($sformatf("v%0d_jmp", v), 64'(jmp_signed), 64'(vecs[v].jmp));
          chk($sformatf("v%0d_regs", v), 64'({rs_addr, rt_addr, rd_addr}), 64'(vecs[v].regs));
        end
        @(negedge clk);
      end
      chk($sformatf("v%0d_next_pc", v), 64'(pc), 64'(vecs[v].nxt));
      chk($sformatf("v%0d_next_addr", v), 64'(imem_addr), 64'(vecs[v].nxt));
      chk($sformatf("v%0d_wr_cnt", v), 64'(n_wr), 64'(vecs[v].wr_cnt));
      chk($sformatf("v%0d_wr_cyc", v), 64'(first_wr), 64'(vecs[v].wr_cyc));
      chk($sformatf("v%0d_rd_cnt", v), 64'(n_rd), 64'(vecs[v].rd_cnt));
      chk($sformatf("v%0d_mtr_cnt", v), 64'(n_mtr), 64'(vecs[v].mtr_cnt));
      chk($sformatf("v%0d_wm_cnt", v), 64'(n_wm), 64'(vecs[v].wm_cnt));
      chk($sformatf("v%0d_ill_cnt", v), 64'(n_ill), 64'(vecs[v].ill_cnt));
    end

    // Asynchronous reset during WB of ADDI
    reset_fill();
    imem[0] = ins_i(6'h01, 4'h0, 4'h2, 16'hFFFB);
    launch();
    repeat (3) @(negedge clk);
    chk("mid_wb_wr", 64'(wr_reg), 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("mid_wb_wr_drop", 64'(wr_reg), 64'h0);
    chk("mid_wb_pc", 64'(pc), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (any_strobe() || pc != '0) bad++;
    end
    chk("post_rst_idle", 64'(bad), 64'h0);

    // HALT at address 9, then resume
    reset_fill();
    imem[9] = 32'hFC00_0000;
    launch();
    repeat (27 + 3) @(negedge clk);
    chk("halt_flag", 64'(halted), 64'h1);
    chk("halt_pc", 64'(pc), 64'd10);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (any_strobe() || !halted || pc != PC_W'(10)) bad++;
    end
    chk("halt_quiet", 64'(bad), 64'h0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("resume_halted", 64'(halted), 64'h0);
    chk("resume_addr", 64'(imem_addr), 64'd10);
    @(negedge clk);
    chk("resume_pc_inc", 64'(pc), 64'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
